// File: rtl/inst_mem_loader.sv
// Serial instruction-memory loader: header byte N, N little-endian words, XOR checksum byte.
// Holds the CPU in reset until a load completes with a matching checksum.
module inst_mem_loader #(
   parameter int unsigned A = 32,
   parameter int unsigned B = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic         wr_en,
   output logic [B-1:0] wr_addr,
   output logic [A-1:0] wr_data,
   output logic         cpu_hold,
   output logic         done,
   output logic         error,
   output logic [B:0]   word_count
);

   localparam int unsigned BytesPerWord = A / 8;
   localparam int unsigned IdxW         = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
   localparam int unsigned MaxWords     = 2 ** B;

   typedef enum logic [2:0] {StIdle, StHdr, StData, StChk, StDone, StError} state_e;

   state_e          state_q, state_d;
   logic            rx_ready_q, rx_ready_d;
   logic            wr_en_q, wr_en_d;
   logic [B-1:0]    wr_addr_q, wr_addr_d;
   logic [A-1:0]    wr_data_q, wr_data_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic [B:0]      word_count_q, word_count_d;
   logic [B:0]      n_words_q, n_words_d;
   logic [IdxW-1:0] byte_idx_q, byte_idx_d;
   logic [7:0]      chk_q, chk_d;
   logic [A-1:0]    asm_q, asm_d;
   logic            accept;
   logic [A-1:0]    asm_next;

   assign accept   = rx_valid && rx_ready_q;
   // Shift new bytes in from the top so the first byte lands in [7:0] after a full word.
   assign asm_next = (asm_q >> 8) | (A'(rx_data) << (A - 8));

   always_comb begin
      state_d      = state_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      n_words_d    = n_words_q;
      byte_idx_d   = byte_idx_q;
      chk_d        = chk_q;
      asm_d        = asm_q;

      case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d      = StHdr;
               word_count_d = '0;
               byte_idx_d   = '0;
               chk_d        = '0;
            end
         end
         StHdr: begin
            if (accept) begin
               if (rx_data == 8'd0 || 32'(rx_data) > MaxWords) begin
                  state_d = StError;
               end else begin
                  n_words_d = (B + 1)'(rx_data);
                  state_d   = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               chk_d = chk_q ^ rx_data;
               asm_d = asm_next;
               if (byte_idx_q == IdxW'(BytesPerWord - 1)) begin
                  byte_idx_d   = '0;
                  wr_en_d      = 1'b1;
                  wr_addr_d    = word_count_q[B-1:0];
                  wr_data_d    = asm_next;
                  word_count_d = word_count_q + 1'b1;
                  if (word_count_q + 1'b1 == n_words_q) state_d = StChk;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
            end
         end
         StChk: begin
            if (accept) state_d = (rx_data == chk_q) ? StDone : StError;
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered, so derive them from the state being entered.
      rx_ready_d = (state_d == StHdr) || (state_d == StData) || (state_d == StChk);
      cpu_hold_d = (state_d != StDone);
      done_d     = (state_d == StDone);
      error_d    = (state_d == StError);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         rx_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         word_count_q <= '0;
         n_words_q    <= '0;
         byte_idx_q   <= '0;
         chk_q        <= '0;
         asm_q        <= '0;
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
         word_count_q <= word_count_d;
         n_words_q    <= n_words_d;
         byte_idx_q   <= byte_idx_d;
         chk_q        <= chk_d;
         asm_q        <= asm_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: single/multi-word loads, bad headers, bad checksum,
// mid-load reset, and gap/start tolerance during DATA.
module tb_inst_mem_loader;

   localparam int unsigned A = 32;
   localparam int unsigned B = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic         wr_en;
   logic [B-1:0] wr_addr;
   logic [A-1:0] wr_data;
   logic         cpu_hold;
   logic         done;
   logic         error;
   logic [B:0]   word_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [B-1:0] wa_log[$];
   logic [A-1:0] wd_log[$];

   inst_mem_loader #(.A(A), .B(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         wa_log.push_back(wr_addr);
         wd_log.push_back(wr_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int g;
      int budget;
      if (gaps) begin
         g = $urandom_range(0, 3);
         for (int i = 0; i < g; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'hA5;
         end
      end
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      budget   = 0;
      while (!rx_ready && budget < 8) begin
         @(negedge clk);
         budget++;
      end
      if (!rx_ready) check_eq("rdy_wait", 64'(rx_ready), 64'd1);
      @(posedge clk);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic load(input logic [7:0] n, input logic [7:0] data[$], input logic [7:0] chk,
                       input bit gaps);
      pulse_start();
      send_byte(n, 1'b0);
      foreach (data[i]) send_byte(data[i], gaps);
      send_byte(chk, gaps);
      bus_idle();
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_rx_ready"}, 64'(rx_ready), 64'd0);
      check_eq({pfx, "_wr_en"}, 64'(wr_en), 64'd0);
      check_eq({pfx, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check_eq({pfx, "_wr_data"}, 64'(wr_data), 64'd0);
      check_eq({pfx, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
      check_eq({pfx, "_done"}, 64'(done), 64'd0);
      check_eq({pfx, "_error"}, 64'(error), 64'd0);
      check_eq({pfx, "_word_count"}, 64'(word_count), 64'd0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] x;
      int         base;

      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_state("rst");

      // Single word, checksum 0x13^0x05^0x10^0x00 = 0x06.
      base = wa_log.size();
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h00, 1'b0);
      bus_idle();
      check_eq("w1_wr_en", 64'(wr_en), 64'd1);
      check_eq("w1_wr_addr", 64'(wr_addr), 64'd0);
      check_eq("w1_wr_data", 64'(wr_data), 64'h00100513);
      check_eq("w1_wcnt_at_wr", 64'(word_count), 64'd1);
      check_eq("w1_rdy_in_chk", 64'(rx_ready), 64'd1);
      send_byte(8'h06, 1'b0);
      bus_idle();
      check_eq("w1_nwrites", 64'(wa_log.size() - base), 64'd1);
      check_eq("w1_done", 64'(done), 64'd1);
      check_eq("w1_error", 64'(error), 64'd0);
      check_eq("w1_cpu_hold", 64'(cpu_hold), 64'd0);
      check_eq("w1_word_count", 64'(word_count), 64'd1);
      check_eq("w1_rx_ready", 64'(rx_ready), 64'd0);

      // Bad headers: N=0 then N=0x41.
      base = wa_log.size();
      pulse_start();
      send_byte(8'h00, 1'b0);
      bus_idle();
      check_eq("n0_error", 64'(error), 64'd1);
      check_eq("n0_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("n0_done", 64'(done), 64'd0);
      check_eq("n0_rx_ready", 64'(rx_ready), 64'd0);
      pulse_start();
      check_eq("retry_clr_error", 64'(error), 64'd0);
      send_byte(8'h41, 1'b0);
      bus_idle();
      check_eq("n41_error", 64'(error), 64'd1);
      check_eq("n41_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("nbad_nwrites", 64'(wa_log.size() - base), 64'd0);

      // Two words, wrong checksum (correct would be 0x88).
      base = wa_log.size();
      q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(8'h02, q, 8'h00, 1'b0);
      check_eq("bc_nwrites", 64'(wa_log.size() - base), 64'd2);
      if (wa_log.size() - base == 2) begin
         check_eq("bc_addr0", 64'(wa_log[base]), 64'd0);
         check_eq("bc_data0", 64'(wd_log[base]), 64'h44332211);
         check_eq("bc_addr1", 64'(wa_log[base+1]), 64'd1);
         check_eq("bc_data1", 64'(wd_log[base+1]), 64'h88776655);
      end
      check_eq("bc_error", 64'(error), 64'd1);
      check_eq("bc_done", 64'(done), 64'd0);
      check_eq("bc_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("bc_word_count", 64'(word_count), 64'd2);

      // Full 64-word load, back-to-back.
      base = wa_log.size();
      q.delete();
      x = 8'h00;
      for (int i = 0; i < 256; i++) begin
         q.push_back(8'((i * 7 + 3) % 256));
         x = x ^ 8'((i * 7 + 3) % 256);
      end
      load(8'h40, q, x, 1'b0);
      check_eq("full_nwrites", 64'(wa_log.size() - base), 64'd64);
      if (wa_log.size() - base == 64) begin
         for (int k = 0; k < 64; k++) begin
            check_eq("full_addr", 64'(wa_log[base+k]), 64'(k));
            check_eq("full_data", 64'(wd_log[base+k]),
                     64'({q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]}));
         end
      end
      check_eq("full_done", 64'(done), 64'd1);
      check_eq("full_word_count", 64'(word_count), 64'd64);

      // Reset after two bytes of word 0, with start and rx_valid also high.
      base = wa_log.size();
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h05, 1'b0);
      @(negedge clk);
      reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h10;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      check_reset_state("midrst");
      repeat (4) @(negedge clk);
      check_eq("midrst_nwrites", 64'(wa_log.size() - base), 64'd0);
      q = '{8'h13, 8'h05, 8'h10, 8'h00};
      load(8'h01, q, 8'h06, 1'b0);
      check_eq("postrst_nwrites", 64'(wa_log.size() - base), 64'd1);
      if (wa_log.size() - base == 1)
         check_eq("postrst_data", 64'(wd_log[base]), 64'h00100513);
      check_eq("postrst_done", 64'(done), 64'd1);

      // Gapped data with a start pulse mid-DATA; must match the gap-free result.
      base = wa_log.size();
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      @(negedge clk);
      rx_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      send_byte(8'h77, 1'b1);
      send_byte(8'h88, 1'b1);
      send_byte(8'h88, 1'b1);
      bus_idle();
      check_eq("gap_nwrites", 64'(wa_log.size() - base), 64'd2);
      if (wa_log.size() - base == 2) begin
         check_eq("gap_addr0", 64'(wa_log[base]), 64'd0);
         check_eq("gap_data0", 64'(wd_log[base]), 64'h44332211);
         check_eq("gap_addr1", 64'(wa_log[base+1]), 64'd1);
         check_eq("gap_data1", 64'(wd_log[base+1]), 64'h88776655);
      end
      check_eq("gap_done", 64'(done), 64'd1);
      check_eq("gap_error", 64'(error), 64'd0);
      check_eq("gap_word_count", 64'(word_count), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
